// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Pipeline register between the execute (ALU) stage and memory/writeback.
//   Captures the ALU result together with destination/control, resolves the
//   branch outcome at capture time, and presents the beat downstream.
//
//   Handshake (both sides): a beat moves when valid & ready are both high at
//   a rising clock edge. A valid beat and its payload stay stable until that
//   edge. InReady is driven from a flop and never depends on OutReady in the
//   same cycle. A two-entry skid buffer (main + skid) still allows one
//   transfer per cycle.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   InValid / InReady              upstream handshake
//   Result, Zero, Rd, RegWrite,    upstream payload (ALU result, zero flag,
//   Branch, BranchNe               destination register, control)
//   Flush                          drops held entries and the incoming beat
//   OutValid / OutReady            downstream handshake
//   OutResult, OutRd,              main entry payload
//   OutRegWrite, BranchTaken
module ex_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [DATA_WIDTH-1:0]     Result,
  input  logic                      Zero,
  input  logic [REG_ADDR_WIDTH-1:0] Rd,
  input  logic                      RegWrite,
  input  logic                      Branch,
  input  logic                      BranchNe,
  input  logic                      Flush,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [DATA_WIDTH-1:0]     OutResult,
  output logic [REG_ADDR_WIDTH-1:0] OutRd,
  output logic                      OutRegWrite,
  output logic                      BranchTaken
);

  // Main entry drives the outputs directly.
  logic                      main_valid;
  logic [DATA_WIDTH-1:0]     main_result;
  logic [REG_ADDR_WIDTH-1:0] main_rd;
  logic                      main_regwrite;
  logic                      main_taken;

  // Skid entry absorbs the beat accepted while main is stalled.
  logic                      skid_valid;
  logic [DATA_WIDTH-1:0]     skid_result;
  logic [REG_ADDR_WIDTH-1:0] skid_rd;
  logic                      skid_regwrite;
  logic                      skid_taken;

  logic accept;
  logic drain;
  logic in_regwrite;
  logic in_taken;

  // Qualified control computed once at capture; writes to x0 never leave
  // this stage. Branch and BranchNe together simply yield taken.
  assign in_regwrite = RegWrite & (Rd != '0);
  assign in_taken    = (Branch & Zero) | (BranchNe & ~Zero);

  assign InReady  = ~skid_valid;
  assign accept   = InValid & InReady;
  assign drain    = main_valid & OutReady;

  assign OutValid    = main_valid;
  assign OutResult   = main_result;
  assign OutRd       = main_rd;
  assign OutRegWrite = main_regwrite;
  assign BranchTaken = main_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid    <= 1'b0;
      main_result   <= '0;
      main_rd       <= '0;
      main_regwrite <= 1'b0;
      main_taken    <= 1'b0;
      skid_valid    <= 1'b0;
      skid_result   <= '0;
      skid_rd       <= '0;
      skid_regwrite <= 1'b0;
      skid_taken    <= 1'b0;
    end else if (Flush) begin
      // Payload registers keep their old contents; only validity matters.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid && drain) begin
      // InReady is low here, so no new beat can arrive this cycle.
      main_result   <= skid_result;
      main_rd       <= skid_rd;
      main_regwrite <= skid_regwrite;
      main_taken    <= skid_taken;
      skid_valid    <= 1'b0;
    end else if (accept && (!main_valid || drain)) begin
      main_valid    <= 1'b1;
      main_result   <= Result;
      main_rd       <= Rd;
      main_regwrite <= in_regwrite;
      main_taken    <= in_taken;
    end else if (accept) begin
      // Main is held and not draining: park the beat in the skid entry.
      skid_valid    <= 1'b1;
      skid_result   <= Result;
      skid_rd       <= Rd;
      skid_regwrite <= in_regwrite;
      skid_taken    <= in_taken;
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic [AW-1:0] rd;
  logic          reg_write;
  logic          branch;
  logic          branch_ne;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [AW-1:0] out_rd;
  logic          out_reg_write;
  logic          branch_taken;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  ex_mem_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .Result      (result),
    .Zero        (zero),
    .Rd          (rd),
    .RegWrite    (reg_write),
    .Branch      (branch),
    .BranchNe    (branch_ne),
    .Flush       (flush),
    .OutValid    (out_valid),
    .OutReady    (out_ready),
    .OutResult   (out_result),
    .OutRd       (out_rd),
    .OutRegWrite (out_reg_write),
    .BranchTaken (branch_taken)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] res,
                       input logic [AW-1:0] r, input logic rw,
                       input logic z, input logic b, input logic bne);
    in_valid  = v;
    result    = res;
    rd        = r;
    reg_write = rw;
    zero      = z;
    branch    = b;
    branch_ne = bne;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Branch vectors: {branch, branch_ne, zero, expected taken}
  logic [3:0] br_tab [5];

  initial begin
    br_tab[0] = 4'b1011; // beq, zero      -> taken
    br_tab[1] = 4'b0110; // bne, zero      -> not taken
    br_tab[2] = 4'b0101; // bne, nonzero   -> taken
    br_tab[3] = 4'b0000; // neither        -> not taken
    br_tab[4] = 4'b1101; // both, nonzero  -> taken
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_regwrite", out_reg_write, 0);
    check("rst_branch_taken", branch_taken, 0);
    rst_n = 1'b1;
    tick();

    // Streaming: one beat per cycle, each appears one cycle later
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), AW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(DW'(i));
      check("stream_in_ready_pre", in_ready, 1);
      tick();
      check("stream_out_valid", out_valid, 1);
      check("stream_out_result", out_result, exp_q.pop_front());
      check("stream_in_ready", in_ready, 1);
    end
    idle();
    tick();
    check("stream_empty", out_valid, 0);
    check("stream_queue_drained", exp_q.size(), 0);

    // Backpressure: fill main and skid, hold, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_a_result", out_result, 32'h10);
    check("bp_a_in_ready", in_ready, 1);
    drive(1'b1, 32'h20, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp_b_in_ready", in_ready, 0);
    check("bp_b_holds_a", out_result, 32'h10);
    drive(1'b1, 32'h30, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // not accepted
    tick();
    check("bp_hold_result", out_result, 32'h10);
    check("bp_hold_rd", out_rd, 1);
    check("bp_hold_in_ready", in_ready, 0);
    idle();
    out_ready = 1'b1;
    tick();
    check("bp_drain_b_result", out_result, 32'h20);
    check("bp_drain_b_valid", out_valid, 1);
    check("bp_drain_in_ready", in_ready, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Branch resolution
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(100 + i), 5'd7, 1'b0, br_tab[i][1], br_tab[i][3],
            br_tab[i][2]);
      tick();
      check($sformatf("branch_%0d", i), branch_taken, br_tab[i][0]);
    end
    idle();
    tick();

    // x0 suppression
    drive(1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("x0_regwrite", out_reg_write, 0);
    check("x0_result", out_result, 32'hDEADBEEF);
    drive(1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("r5_regwrite", out_reg_write, 1);
    check("r5_rd", out_rd, 5);
    drive(1'b1, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("r5_no_regwrite", out_reg_write, 0);
    idle();
    tick();

    // Flush with both entries full and a beat presented
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hA2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("flush_full_in_ready", in_ready, 0);
    drive(1'b1, 32'hA3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    idle();
    out_ready = 1'b1;
    tick();
    check("flush_no_ghost_1", out_valid, 0);
    tick();
    check("flush_no_ghost_2", out_valid, 0);
    // Flush drops even a beat that was accepted into an empty stage
    drive(1'b1, 32'hA4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_accepted_dropped", out_valid, 0);
    idle();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h66, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_in_ready", in_ready, 0);
    check("pre_rst_taken", branch_taken, 1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_result", out_result, 0);
    check("arst_out_rd", out_rd, 0);
    check("arst_out_regwrite", out_reg_write, 0);
    check("arst_branch_taken", branch_taken, 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h77, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_empty", out_valid, 0);
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", out_result, 32'h77);
    check("post_rst_rd", out_rd, 11);
    idle();
    tick();
    check("post_rst_drained", out_valid, 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
